// File: rtl/dvid_timing_pkg.sv
// ============================================================================
// Module      : dvid_timing_pkg
// Description : 640x480@60 timing constants, control codes and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dvid_timing_pkg;

  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;

  localparam int c_cnt_max  = 2047;

  // {vsync,hsync} control codes for the default active-low sync polarity
  localparam logic [1:0] c_ctl_idle   = 2'b11;
  localparam logic [1:0] c_ctl_hsync  = 2'b10;
  localparam logic [1:0] c_ctl_vsync  = 2'b01;
  localparam logic [1:0] c_ctl_vhsync = 2'b00;

  typedef struct packed {
    logic blank;
    logic vsync;
    logic hsync;
  } ctl_t;

  function automatic logic in_window(input logic [10:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dvid_delay.sv
// ============================================================================
// Module      : dvid_delay
// Description : WIDTH x DEPTH shift register with synchronous reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvid_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/dvid_timing.sv
// ============================================================================
// Module      : dvid_timing
// Description : DVI/TMDS raster timing generator with latency-aligned controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvid_timing
  import dvid_timing_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int H_FP     = c_h_fp,
  parameter int H_SYNC   = c_h_sync,
  parameter int H_BP     = c_h_bp,
  parameter int V_ACTIVE = c_v_active,
  parameter int V_FP     = c_v_fp,
  parameter int V_SYNC   = c_v_sync,
  parameter int V_BP     = c_v_bp,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        pix_req,
  output logic        frame_start,
  output logic        blank,
  output logic [1:0]  c,
  output logic [7:0]  frame_count
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_h_last = 11'(c_h_total - 1);
  localparam logic [10:0] c_v_last = 11'(c_v_total - 1);
  localparam logic [10:0] c_h_vis  = 11'(H_ACTIVE);
  localparam logic [10:0] c_v_vis  = 11'(V_ACTIVE);
  localparam logic [10:0] c_hs_lo  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_hi  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_vs_lo  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_vs_hi  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        c_hs_on  = 1'(HS_POL);
  localparam logic        c_vs_on  = 1'(VS_POL);
  localparam ctl_t        c_ctl_rst = '{blank: 1'b1, vsync: ~c_vs_on, hsync: ~c_hs_on};

  if (c_h_total > c_cnt_max || c_v_total > c_cnt_max) begin : g_bad_total
    $error("dvid_timing: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("dvid_timing: LATENCY must be in 1..4");
  end

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic [10:0] w_hcount_nxt;
  logic [10:0] w_vcount_nxt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        r_pix_req;
  logic        r_frame_start;
  logic        r_run;
  logic [7:0]  r_frame_count;
  ctl_t        w_ctl_in;
  ctl_t        w_ctl_out;

  always_comb begin
    w_h_wrap     = (r_hcount == c_h_last);
    w_v_wrap     = w_h_wrap && (r_vcount == c_v_last);
    w_hcount_nxt = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
    w_vcount_nxt = r_vcount;
    if (w_v_wrap) begin
      w_vcount_nxt = 11'd0;
    end else if (w_h_wrap) begin
      w_vcount_nxt = r_vcount + 11'd1;
    end
  end

  // Reset parks the counters on the last pixel so the first live edge lands
  // on (0,0); that reset-exit wrap is not a completed frame, hence r_run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount      <= c_h_last;
      r_vcount      <= c_v_last;
      r_pix_req     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
      r_run         <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_pix_req     <= (w_hcount_nxt < c_h_vis) && (w_vcount_nxt < c_v_vis);
      r_frame_start <= w_v_wrap;
      r_run         <= 1'b1;
      if (w_v_wrap && r_run) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_ctl_in.blank = ~r_pix_req;
    w_ctl_in.hsync = in_window(r_hcount, c_hs_lo, c_hs_hi) ? c_hs_on : ~c_hs_on;
    w_ctl_in.vsync = in_window(r_vcount, c_vs_lo, c_vs_hi) ? c_vs_on : ~c_vs_on;
  end

  dvid_delay #(
    .WIDTH   (3),
    .DEPTH   (LATENCY),
    .RST_VAL (c_ctl_rst)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (w_ctl_in),
    .dout  (w_ctl_out)
  );

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign pix_req     = r_pix_req;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign blank       = w_ctl_out.blank;
  assign c           = {w_ctl_out.vsync, w_ctl_out.hsync};

endmodule

`default_nettype wire

// File: tb/tb_dvid_timing.sv
// ============================================================================
// Module      : tb_dvid_timing
// Description : Self-checking bench: default 640x480 instance plus a small
//               LATENCY=4 / positive-polarity instance against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dvid_timing;
  import dvid_timing_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic        d_pix_req, d_frame_start, d_blank;
  logic        s_pix_req, s_frame_start, s_blank;
  logic [1:0]  d_c, s_c;
  logic [7:0]  d_frame_count, s_frame_count;

  dvid_timing u_def (
    .clk (clk), .reset (reset),
    .hcount (d_hcount), .vcount (d_vcount), .pix_req (d_pix_req),
    .frame_start (d_frame_start), .blank (d_blank), .c (d_c),
    .frame_count (d_frame_count)
  );

  dvid_timing #(
    .H_ACTIVE (20), .H_FP (4), .H_SYNC (6), .H_BP (5),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (3), .V_BP (4),
    .HS_POL (1), .VS_POL (1), .LATENCY (4)
  ) u_sml (
    .clk (clk), .reset (reset),
    .hcount (s_hcount), .vcount (s_vcount), .pix_req (s_pix_req),
    .frame_start (s_frame_start), .blank (s_blank), .c (s_c),
    .frame_count (s_frame_count)
  );

  // Instance 0 = default, instance 1 = small
  int ha  [2] = '{640, 20};
  int hf  [2] = '{16, 4};
  int hsw [2] = '{96, 6};
  int hb  [2] = '{48, 5};
  int va  [2] = '{480, 12};
  int vf  [2] = '{10, 2};
  int vsw [2] = '{2, 3};
  int vb  [2] = '{33, 4};
  int hp  [2] = '{0, 1};
  int vp  [2] = '{0, 1};
  int lat [2] = '{2, 4};

  int tests = 0;
  int fails = 0;
  int t = 0;  // edges since reset released; 0 while held in reset

  function automatic int h_tot(int i);
    return ha[i] + hf[i] + hsw[i] + hb[i];
  endfunction

  function automatic int v_tot(int i);
    return va[i] + vf[i] + vsw[i] + vb[i];
  endfunction

  // {blank, vsync, hsync} for linear raster position lin
  function automatic logic [2:0] ctl_of(int i, int lin);
    int h, v;
    logic pix, hs, vs;
    h   = lin % h_tot(i);
    v   = lin / h_tot(i);
    pix = (h < ha[i]) && (v < va[i]);
    hs  = (h >= ha[i] + hf[i] && h < ha[i] + hf[i] + hsw[i]) ? (hp[i] != 0) : (hp[i] == 0);
    vs  = (v >= va[i] + vf[i] && v < va[i] + vf[i] + vsw[i]) ? (vp[i] != 0) : (vp[i] == 0);
    return {!pix, vs, hs};
  endfunction

  function automatic logic [34:0] expect_vec(int i, int tt);
    int tot, lin, h, v, fc, dl;
    logic pix, fs;
    logic [2:0] ctl;
    tot = h_tot(i) * v_tot(i);
    lin = (tt - 1 + tot) % tot;
    h   = lin % h_tot(i);
    v   = lin / h_tot(i);
    pix = (h < ha[i]) && (v < va[i]);
    fs  = (tt >= 1) && (lin == 0);
    fc  = (tt >= 1) ? ((tt - 1) / tot) % 256 : 0;
    dl  = tt - lat[i];
    if (dl < 0) ctl = {1'b1, vp[i] == 0, hp[i] == 0};
    else        ctl = ctl_of(i, (dl - 1 + tot) % tot);
    return {11'(h), 11'(v), pix, fs, 8'(fc), ctl};
  endfunction

  always @(posedge clk) begin
    logic [34:0] act, exp_v;
    if (reset) t = 0;
    else       t = t + 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) act = {d_hcount, d_vcount, d_pix_req, d_frame_start, d_frame_count, d_blank, d_c};
      else        act = {s_hcount, s_vcount, s_pix_req, s_frame_start, s_frame_count, s_blank, s_c};
      exp_v = expect_vec(i, t);
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL model_inst%0d t=%0d: got h=%0d v=%0d pix=%0b fs=%0b fc=%0d blank=%0b c=%b, required h=%0d v=%0d pix=%0b fs=%0b fc=%0d blank=%0b c=%b",
                 i, t, act[34:24], act[23:13], act[12], act[11], act[10:3], act[2], act[1:0],
                 exp_v[34:24], exp_v[23:13], exp_v[12], exp_v[11], exp_v[10:3], exp_v[2], exp_v[1:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    reset = 1'b1;
    step(3);
    chk("rst_hcount", d_hcount, 799);
    chk("rst_vcount", d_vcount, 524);
    chk("rst_pix_req", d_pix_req, 0);
    chk("rst_frame_start", d_frame_start, 0);
    chk("rst_frame_count", d_frame_count, 0);
    chk("rst_blank", d_blank, 1);
    chk("rst_c", d_c, c_ctl_idle);
    chk("rst_sml_hcount", s_hcount, 34);
    chk("rst_sml_vcount", s_vcount, 20);
    chk("rst_sml_c", s_c, 0);

    @(negedge clk) reset = 1'b0;
    step(1);
    chk("c1_hcount", d_hcount, 0);
    chk("c1_vcount", d_vcount, 0);
    chk("c1_pix_req", d_pix_req, 1);
    chk("c1_frame_start", d_frame_start, 1);
    chk("c1_blank", d_blank, 1);
    step(1);
    chk("c2_blank", d_blank, 1);
    chk("c2_frame_start", d_frame_start, 0);
    step(1);
    chk("c3_blank", d_blank, 0);

    step(797);
    chk("c800_hcount", d_hcount, 799);
    chk("c800_vcount", d_vcount, 0);
    chk("c800_pix_req", d_pix_req, 0);
    step(1);
    chk("c801_hcount", d_hcount, 0);
    chk("c801_vcount", d_vcount, 1);
    chk("c801_pix_req", d_pix_req, 1);

    step(657);
    chk("hs_before_hcount", d_hcount, 657);
    chk("hs_before_c0", d_c[0], 1);
    step(1);
    chk("hs_first_c", d_c, c_ctl_hsync);
    step(95);
    chk("hs_last_c0", d_c[0], 0);
    step(1);
    chk("hs_after_c0", d_c[0], 1);
    chk("sml_frame_count_c1555", s_frame_count, 2);

    @(negedge clk) reset = 1'b1;
    step(1);
    chk("mid_rst_hcount", d_hcount, 799);
    chk("mid_rst_vcount", d_vcount, 524);
    chk("mid_rst_pix_req", d_pix_req, 0);
    chk("mid_rst_blank", d_blank, 1);
    chk("mid_rst_c", d_c, c_ctl_idle);
    chk("mid_rst_sml_fc", s_frame_count, 0);
    chk("mid_rst_sml_hcount", s_hcount, 34);
    chk("mid_rst_sml_blank", s_blank, 1);
    chk("mid_rst_sml_c", s_c, 0);
    step(2);
    @(negedge clk) reset = 1'b0;

    step(1);
    chk("re_sml_hcount", s_hcount, 0);
    chk("re_sml_frame_start", s_frame_start, 1);
    chk("re_def_frame_start", d_frame_start, 1);
    step(3);
    chk("re_sml_c4_blank", s_blank, 1);
    step(1);
    chk("re_sml_c5_blank", s_blank, 0);
    step(23);
    chk("sml_hs_before_c0", s_c[0], 0);
    step(1);
    chk("sml_hs_hcount", s_hcount, 28);
    chk("sml_hs_first_c0", s_c[0], 1);

    step(2300);
    chk("sml_frame_count_end", s_frame_count, 3);
    chk("def_vcount_end", d_vcount, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
